// File: rtl/race_pkg.sv
// race_pkg: shared encodings for the race game sequencer and the physics engine.
//   state_e  - 3-bit game state broadcast to physics engines and renderers
//   op_e     - player operation codes consumed by the physics engine
//   W_*      - winner codes reported by the sequencer
package race_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTING   = 3'd1,
    COUNTDOWN = 3'd3,
    RACING    = 3'd4,
    PAUSE     = 3'd5,
    FINISH    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    NIL      = 3'd0,
    FORWARD  = 3'd1,
    BACKWARD = 3'd2,
    LEFT     = 3'd3,
    RIGHT    = 3'd4
  } op_e;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_TIE  = 2'b11;

endpackage

// File: rtl/race_state_controller_if.sv
// race_state_controller_if: button/lap pulses in, game status out.
//   master - the input side (debouncers, lap-line detectors)
//   slave  - the sequencer that consumes pulses and drives game status
interface race_state_controller_if;
  logic       start_pulse;
  logic       pause_pulse;
  logic       p1_lap;
  logic       p2_lap;
  logic [2:0] state;
  logic       physics_tick;
  logic [3:0] countdown_val;
  logic [3:0] p1_laps;
  logic [3:0] p2_laps;
  logic [1:0] winner;
  logic [9:0] race_time_s;

  modport master (
    output start_pulse, pause_pulse, p1_lap, p2_lap,
    input  state, physics_tick, countdown_val, p1_laps, p2_laps, winner, race_time_s
  );

  modport slave (
    input  start_pulse, pause_pulse, p1_lap, p2_lap,
    output state, physics_tick, countdown_val, p1_laps, p2_laps, winner, race_time_s
  );
endinterface

// File: rtl/game_tick_divider.sv
// game_tick_divider: divides clk into game ticks.
//   clk, rst - clock, synchronous active-high reset
//   enable   - count while high
//   hold     - freeze the count (takes precedence over enable)
//   clear    - force the count to 0
//   tick     - one-cycle pulse on the cycle the count wraps TICK_DIV-1 -> 0
module game_tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic         run;

  assign run  = enable && !hold && !clear;
  assign tick = run && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/race_state_controller.sv
// race_state_controller: top-level game sequencer.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of race_state_controller_if:
//              start/pause/lap pulses in; state, physics_tick, countdown_val,
//              lap counts, winner and race_time_s out (all registered)
// Build option: define RACE_TIMEOUT_EN to end the race after TIMEOUT_SECS.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | attract screen, waiting for start
// SETTING   | setup screen, start confirms and begins countdown
// COUNTDOWN | counting down seconds, all buttons ignored
// RACING    | physics running, laps and race time counting
// PAUSE     | everything frozen, pause resumes
// FINISH    | results shown, start returns to IDLE
// (code 2 and other undefined codes fall back to IDLE)
module race_state_controller
  import race_pkg::*;
#(
  parameter int TICK_DIV       = 4,
  parameter int TICKS_PER_SEC  = 5,
  parameter int COUNTDOWN_SECS = 3,
  parameter int LAPS_TO_WIN    = 3,
  parameter int TIMEOUT_SECS   = 600
) (
  input logic clk,
  input logic rst,
  race_state_controller_if.slave bus
);

  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    LAPS_WIN = 4'(LAPS_TO_WIN);

  state_e        state_q;
  logic          phys_q;
  logic [3:0]    cd_q;
  logic [3:0]    p1_q;
  logic [3:0]    p2_q;
  logic [1:0]    win_q;
  logic [9:0]    rt_q;
  logic [SW-1:0] sub_q;

  logic          tick;
  logic          sec_evt;
  logic          div_en;
  logic          div_hold;
  logic          div_clr;
  logic [3:0]    p1_d;
  logic [3:0]    p2_d;
  logic [9:0]    rt_d;
  logic          p1_won;
  logic          p2_won;

  // PAUSE holds the divider; any state other than COUNTDOWN/RACING/PAUSE
  // clears it, which also guarantees a zero count on entry to COUNTDOWN.
  assign div_en   = (state_q == COUNTDOWN) || (state_q == RACING);
  assign div_hold = (state_q == PAUSE);
  assign div_clr  = !(div_en || div_hold);

  game_tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (div_en),
    .hold   (div_hold),
    .clear  (div_clr),
    .tick   (tick)
  );

  assign sec_evt = tick && (sub_q == SUB_LAST);

  // Lap/time next values; only committed while RACING.
  assign p1_d   = (bus.p1_lap && p1_q != 4'hF) ? p1_q + 4'd1 : p1_q;
  assign p2_d   = (bus.p2_lap && p2_q != 4'hF) ? p2_q + 4'd1 : p2_q;
  assign rt_d   = (sec_evt && rt_q != 10'h3FF) ? rt_q + 10'd1 : rt_q;
  assign p1_won = (p1_d >= LAPS_WIN);
  assign p2_won = (p2_d >= LAPS_WIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phys_q  <= 1'b0;
      cd_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= W_NONE;
      rt_q    <= '0;
      sub_q   <= '0;
    end else begin
      phys_q <= tick && (state_q == RACING);

      if (div_clr) begin
        sub_q <= '0;
      end else if (tick) begin
        sub_q <= sec_evt ? '0 : sub_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.start_pulse) state_q <= SETTING;
        end

        SETTING: begin
          if (bus.start_pulse) begin
            state_q <= COUNTDOWN;
            cd_q    <= 4'(COUNTDOWN_SECS);
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= W_NONE;
            rt_q    <= '0;
          end
        end

        COUNTDOWN: begin
          if (sec_evt) begin
            if (cd_q == 4'd1) begin
              state_q <= RACING;
              cd_q    <= '0;
            end else begin
              cd_q <= cd_q - 4'd1;
            end
          end
        end

        RACING: begin
          p1_q <= p1_d;
          p2_q <= p2_d;
          rt_q <= rt_d;
          if (p1_won || p2_won) begin
            state_q <= FINISH;
            win_q   <= (p1_won && p2_won) ? W_TIE : (p1_won ? W_P1 : W_P2);
          end
`ifdef RACE_TIMEOUT_EN
          else if (rt_d >= 10'(TIMEOUT_SECS)) begin
            state_q <= FINISH;
            win_q   <= (p1_d > p2_d) ? W_P1 : ((p2_d > p1_d) ? W_P2 : W_TIE);
          end
`endif
          else if (bus.pause_pulse) begin
            state_q <= PAUSE;
          end
        end

        PAUSE: begin
          if (bus.pause_pulse) state_q <= RACING;
        end

        FINISH: begin
          if (bus.start_pulse) begin
            state_q <= IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= W_NONE;
            rt_q    <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
          cd_q    <= '0;
          p1_q    <= '0;
          p2_q    <= '0;
          win_q   <= W_NONE;
          rt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.physics_tick  = phys_q;
  assign bus.countdown_val = cd_q;
  assign bus.p1_laps       = p1_q;
  assign bus.p2_laps       = p2_q;
  assign bus.winner        = win_q;
  assign bus.race_time_s   = rt_q;

endmodule

// File: tb/tb_race_state_controller.sv
// Directed bench for race_state_controller with default parameters.
module tb_race_state_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  race_state_controller_if bus ();

  race_state_controller #(
    .TICK_DIV       (4),
    .TICKS_PER_SEC  (5),
    .COUNTDOWN_SECS (3),
    .LAPS_TO_WIN    (3),
    .TIMEOUT_SECS   (600)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_pulse = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.p1_lap      = 1'b0;
    bus.p2_lap      = 1'b0;
  endtask

  task automatic press_start();
    bus.start_pulse = 1'b1;
    step();
    bus.start_pulse = 1'b0;
  endtask

  int nt;
  int last;
  int gap_bad;
  int bad_state;

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_phys", 32'(bus.physics_tick), 0);
    chk("rst_cd", 32'(bus.countdown_val), 0);
    chk("rst_p1", 32'(bus.p1_laps), 0);
    chk("rst_p2", 32'(bus.p2_laps), 0);
    chk("rst_win", 32'(bus.winner), 0);
    chk("rst_rt", 32'(bus.race_time_s), 0);
    rst = 1'b0;

    press_start();
    chk("to_setting", 32'(bus.state), 1);
    press_start();
    chk("to_countdown", 32'(bus.state), 3);
    chk("cd_start", 32'(bus.countdown_val), 3);

    // countdown: cd 2 at +20, 1 at +40, RACING at +60
    nt = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      nt += int'(bus.physics_tick);
      if (i == 20) chk("cd_at_20", 32'(bus.countdown_val), 2);
      if (i == 40) chk("cd_at_40", 32'(bus.countdown_val), 1);
      if (i == 59) chk("still_cd_at_59", 32'(bus.state), 3);
    end
    chk("no_phys_in_cd", 32'(nt), 0);
    chk("racing_at_60", 32'(bus.state), 4);
    chk("cd_zero_racing", 32'(bus.countdown_val), 0);

    // 40 idle racing cycles
    nt = 0; last = -1; gap_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.physics_tick === 1'b1) begin
        nt++;
        if (last >= 0 && (i - last) != 4) gap_bad++;
        last = i;
      end
    end
    chk("phys_count_40", 32'(nt), 10);
    chk("phys_spacing", 32'(gap_bad), 0);
    chk("rt_after_40", 32'(bus.race_time_s), 2);

    // pause while divider count is 2
    step();
    step();
    bus.pause_pulse = 1'b1;
    step();
    bus.pause_pulse = 1'b0;
    chk("to_pause", 32'(bus.state), 5);
    nt = 0; bad_state = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 25) bus.p1_lap = 1'b1;
      step();
      bus.p1_lap = 1'b0;
      nt += int'(bus.physics_tick);
      if (bus.state !== 3'd5) bad_state++;
    end
    chk("phys_in_pause", 32'(nt), 0);
    chk("pause_stays", 32'(bad_state), 0);
    chk("rt_frozen", 32'(bus.race_time_s), 2);
    chk("lap_dropped_pause", 32'(bus.p1_laps), 0);
    bus.pause_pulse = 1'b1;
    step();
    bus.pause_pulse = 1'b0;
    chk("resume_state", 32'(bus.state), 4);
    chk("resume_phys_1", 32'(bus.physics_tick), 0);
    step();
    chk("resume_phys_2", 32'(bus.physics_tick), 1);

    // P1 wins with three laps
    bus.p1_lap = 1'b1; step(); bus.p1_lap = 1'b0;
    chk("p1_lap1", 32'(bus.p1_laps), 1);
    step();
    bus.p1_lap = 1'b1; step(); bus.p1_lap = 1'b0;
    chk("p1_lap2", 32'(bus.p1_laps), 2);
    chk("racing_lap2", 32'(bus.state), 4);
    step();
    bus.p1_lap = 1'b1; step(); bus.p1_lap = 1'b0;
    chk("p1_lap3", 32'(bus.p1_laps), 3);
    chk("finish_state", 32'(bus.state), 6);
    chk("winner_p1", 32'(bus.winner), 1);
    bus.p2_lap = 1'b1; step(); bus.p2_lap = 1'b0;
    chk("p2_frozen_finish", 32'(bus.p2_laps), 0);
    chk("finish_holds", 32'(bus.state), 6);
    chk("rt_hold_finish", 32'(bus.race_time_s), 2);
    press_start();
    chk("finish_to_idle", 32'(bus.state), 0);
    chk("idle_p1_clr", 32'(bus.p1_laps), 0);
    chk("idle_win_clr", 32'(bus.winner), 0);
    chk("idle_rt_clr", 32'(bus.race_time_s), 0);

    // tie: both reach 3 in the same cycle as a pause pulse
    press_start();
    press_start();
    for (int i = 1; i <= 60; i++) step();
    chk("race2_racing", 32'(bus.state), 4);
    for (int k = 0; k < 2; k++) begin
      bus.p1_lap = 1'b1; bus.p2_lap = 1'b1;
      step();
      idle_inputs();
      step();
    end
    chk("tie_p1_2", 32'(bus.p1_laps), 2);
    chk("tie_p2_2", 32'(bus.p2_laps), 2);
    bus.p1_lap = 1'b1; bus.p2_lap = 1'b1; bus.pause_pulse = 1'b1;
    step();
    idle_inputs();
    chk("tie_state", 32'(bus.state), 6);
    chk("tie_winner", 32'(bus.winner), 3);
    chk("tie_p1_3", 32'(bus.p1_laps), 3);
    chk("tie_p2_3", 32'(bus.p2_laps), 3);
    press_start();
    chk("tie_to_idle", 32'(bus.state), 0);

    // reset during countdown with countdown_val == 2
    press_start();
    press_start();
    chk("cd3_again", 32'(bus.countdown_val), 3);
    for (int i = 1; i <= 20; i++) step();
    chk("cd2_before_rst", 32'(bus.countdown_val), 2);
    rst = 1'b1;
    bus.start_pulse = 1'b1;
    bus.pause_pulse = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    chk("rst_cd_state", 32'(bus.state), 0);
    chk("rst_cd_val", 32'(bus.countdown_val), 0);

    // divider and subcounter restart from zero after the reset
    press_start();
    press_start();
    for (int i = 1; i <= 19; i++) step();
    chk("cd3_at_19", 32'(bus.countdown_val), 3);
    step();
    chk("cd2_at_20", 32'(bus.countdown_val), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/race_state_controller.md
Name: race_state_controller

Overview:
Top-level game sequencer for the racing game. It generates the 3-bit `state` consumed by each player's physics engine and renderer. It also produces the physics update strobe, runs the start countdown, counts laps for two players, and declares the winner. The block sits between the button debouncers / lap-line detectors and the physics engines.

Parameters:
- TICK_DIV, 4, clk cycles per game tick (≥2).
- TICKS_PER_SEC, 5, game ticks per displayed second (≥1).
- COUNTDOWN_SECS, 3, countdown start value (1..15).
- LAPS_TO_WIN, 3, laps needed to win (1..15).
- TIMEOUT_SECS, 600, race time limit; used only with RACE_TIMEOUT_EN.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- start_pulse, input, 1, one-cycle start/confirm button pulse.
- pause_pulse, input, 1, one-cycle pause toggle pulse.
- p1_lap, input, 1, one-cycle pulse when player 1 crosses the finish line.
- p2_lap, input, 1, one-cycle pulse when player 2 crosses the finish line.
- state, output, 3, game state: IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6.
- physics_tick, output, 1, one-cycle physics update enable.
- countdown_val, output, 4, seconds remaining; 0 outside COUNTDOWN.
- p1_laps, output, 4, player 1 completed laps.
- p2_laps, output, 4, player 2 completed laps.
- winner, output, 2, 00 none, 01 P1, 10 P2, 11 tie.
- race_time_s, output, 10, elapsed racing seconds.

Behaviour:
- Reset: all outputs are 0, so state=IDLE. The tick divider and seconds subcounter are cleared.
- All outputs are registered. A transition is visible the cycle after the triggering input is sampled.
- Tick divider:
  - Counts 0..TICK_DIV-1 while state is COUNTDOWN or RACING.
  - Holds its value in PAUSE.
  - Is forced to 0 in any other state and on entry to COUNTDOWN.
  - An internal tick fires on the cycle the count wraps.
  - physics_tick equals the internal tick, qualified by state==RACING. It is 0 in all other states.
- Seconds subcounter: counts ticks 0..TICKS_PER_SEC-1. Its wrap is a "second" event.
- IDLE:
  - start_pulse moves to SETTING.
  - Unused encoding 2, or any other undefined value, returns to IDLE on the next cycle.
- SETTING: start_pulse moves to COUNTDOWN. On that move:
  - countdown_val=COUNTDOWN_SECS.
  - Laps, winner and race_time_s are cleared.
- COUNTDOWN:
  - Each second event decrements countdown_val.
  - A second event while countdown_val==1 moves to RACING and sets countdown_val=0.
  - RACING is first visible exactly COUNTDOWN_SECS×TICKS_PER_SEC×TICK_DIV cycles after COUNTDOWN is first visible.
  - pause_pulse, start_pulse and lap pulses are ignored.
- RACING:
  - A lap pulse increments that player's count, saturating at 15.
  - If either count reaches LAPS_TO_WIN, the block moves to FINISH and latches winner:
    - 01 if only P1 reached it;
    - 10 if only P2 reached it;
    - 11 if both reached it in the same cycle.
  - Each second event increments race_time_s, saturating at 1023.
  - pause_pulse moves to PAUSE.
  - Priority: finish over pause. A lap pulse in the same cycle as pause_pulse is still counted.
  - start_pulse is ignored.
- PAUSE:
  - Laps, timer, divider and subcounter are frozen.
  - Lap pulses are dropped.
  - pause_pulse returns to RACING, and the divider resumes from its held count.
  - start_pulse is ignored.
- FINISH:
  - All counters and winner hold.
  - start_pulse moves to IDLE, which clears laps, winner and race_time_s on entry.
- Asserting rst mid-countdown or mid-race returns to IDLE on the next edge, regardless of other inputs.

Optional Feature:
- Macro: RACE_TIMEOUT_EN.
- Defined: in RACING, when race_time_s reaches TIMEOUT_SECS, the block moves to FINISH with winner set to the player with more laps, or 11 if laps are equal. A lap-win in the same cycle takes priority over timeout.
- Undefined: no timeout logic is built. race_time_s still counts and saturates, and TIMEOUT_SECS is unused.

Decomposition:
- Package race_pkg holds:
  - the state codes IDLE/SETTING/COUNTDOWN/RACING/PAUSE/FINISH;
  - the operation codes NIL/FORWARD/BACKWARD/LEFT/RIGHT;
  - the winner codes.
- The physics engine and this block share race_pkg.
- One sub-module, game_tick_divider:
  - Inputs: enable (run), hold (pause), clear.
  - Output: a one-cycle tick.
  - Parameter: TICK_DIV.

Test Plan (defaults TICK_DIV=4, TICKS_PER_SEC=5, COUNTDOWN_SECS=3, LAPS_TO_WIN=3):
- rst high for 2 cycles, then start_pulse twice → state 0→1→3 with countdown_val=3. countdown_val reads 2 after 20 cycles and 1 after 40. state=4 at cycle 60, with no physics_tick before that.
- In RACING, hold inputs idle for 40 cycles → physics_tick fires exactly 10 times, each 4 cycles apart, and race_time_s=2.
- pause_pulse at divider count 2, wait 50 cycles, pause_pulse again → physics_tick stays 0 and race_time_s is unchanged while paused. The first tick comes 2 cycles after resume.
- Send p1_lap ×3 → winner=01 and state=6. Subsequent p2_lap pulses leave p2_laps unchanged. start_pulse then gives state=0 with laps, winner and race_time_s at 0.
- With both players at 2 laps, pulse p1_lap and p2_lap in the same cycle together with pause_pulse → state=6, winner=11, counts 3/3.
- Assert rst during COUNTDOWN with countdown_val=2 → next cycle state=0 and countdown_val=0. Force-sequence state encoding 2 where possible to check that it recovers to IDLE.
